// File: rtl/sound_seek_sequencer_pkg.sv
// Shared definitions for the sound-seek sequencer: direction codes, FSM
// state encoding and the timer width helper.
package sound_seek_sequencer_pkg;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_AHEAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_MEASURE  = 3'd2,
        ST_DECIDE   = 3'd3,
        ST_ISSUE    = 3'd4,
        ST_COOLDOWN = 3'd5
    } state_e;

    // Width of a down-counter able to hold the largest of three cycle counts.
    // Counts are loaded as N-1, so $clog2(N) bits always suffice.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/sound_seek_sequencer_cycle_timer.sv
// Loadable down-counter shared by the settle, window and cooldown phases.
// done_o is high while the count sits at zero; loading N-1 therefore gives a
// phase that lasts exactly N cycles including the cycle where done_o is seen.
module sound_seek_sequencer_cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins, otherwise count down and rest at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/sound_seek_sequencer.sv
// Sequencer for the FindSound mic-pair detector in sound-seeking mode.
// Enables the detector, skips its settling time, takes one filtered direction
// sample per window, majority-votes over VOTES windows and hands the winning
// heading to the drive controller, keeping the detector off while turning.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | seek mode disarmed, detector off
//   SETTLE   | detector on, output ignored while it settles
//   MEASURE  | detector on, one sample on the last cycle of each window
//   DECIDE   | one cycle: evaluate the vote
//   ISSUE    | detector off, heading command offered on valid/ready
//   COOLDOWN | detector off while the robot turns
module sound_seek_sequencer
    import sound_seek_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 200_000,
    parameter int unsigned WINDOW_CYCLES   = 1_000_000,
    parameter int unsigned VOTES           = 5,
    parameter int unsigned COOLDOWN_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       find_enable,
    input  logic [1:0] direction,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_dir,
    output logic [2:0] cmd_confidence,
    output logic       busy
);

    localparam int unsigned TMR_W    = timer_width(SETTLE_CYCLES, WINDOW_CYCLES, COOLDOWN_CYCLES);
    localparam logic [2:0]  MAJORITY = 3'(VOTES / 2);
    localparam logic [2:0]  LAST_WIN = 3'(VOTES - 1);

    state_e state_q, state_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_done;

    logic [2:0] tally_l_q, tally_l_d;
    logic [2:0] tally_r_q, tally_r_d;
    logic [2:0] tally_a_q, tally_a_d;
    logic [2:0] tally_n_q, tally_n_d;
    logic [2:0] win_cnt_q, win_cnt_d;
    logic [1:0] dir_prev_q;
    logic [1:0] cmd_dir_q, cmd_dir_d;
    logic [2:0] cmd_conf_q, cmd_conf_d;

    logic [1:0] sample;
    logic       win_found;
    logic [1:0] win_dir;
    logic [2:0] win_tally;
    logic       clear;

    sound_seek_sequencer_cycle_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .done_o  (tmr_done)
    );

    // A direction only counts if it was already present the cycle before;
    // a reading that just changed is treated as no detection.
    assign sample = (direction == dir_prev_q) ? direction : DIR_NONE;

    // Winner: strictly largest L/R/A tally that is also a majority of VOTES.
    always_comb begin
        win_found = 1'b0;
        win_dir   = DIR_NONE;
        win_tally = '0;
        if ((tally_l_q > tally_r_q) && (tally_l_q > tally_a_q) && (tally_l_q > MAJORITY)) begin
            win_found = 1'b1;
            win_dir   = DIR_LEFT;
            win_tally = tally_l_q;
        end else if ((tally_r_q > tally_l_q) && (tally_r_q > tally_a_q) && (tally_r_q > MAJORITY)) begin
            win_found = 1'b1;
            win_dir   = DIR_RIGHT;
            win_tally = tally_r_q;
        end else if ((tally_a_q > tally_l_q) && (tally_a_q > tally_r_q) && (tally_a_q > MAJORITY)) begin
            win_found = 1'b1;
            win_dir   = DIR_AHEAD;
            win_tally = tally_a_q;
        end
    end

    // Next-state, timer control, tally and command updates.
    always_comb begin
        state_d    = state_q;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        tally_l_d  = tally_l_q;
        tally_r_d  = tally_r_q;
        tally_a_d  = tally_a_q;
        tally_n_d  = tally_n_q;
        win_cnt_d  = win_cnt_q;
        cmd_dir_d  = cmd_dir_q;
        cmd_conf_d = cmd_conf_q;
        clear      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(SETTLE_CYCLES - 1);
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!start) begin
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmr_done) begin
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(WINDOW_CYCLES - 1);
                    state_d   = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (!start) begin
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmr_done) begin
                    case (sample)
                        DIR_LEFT:  tally_l_d = tally_l_q + 3'd1;
                        DIR_RIGHT: tally_r_d = tally_r_q + 3'd1;
                        DIR_AHEAD: tally_a_d = tally_a_q + 3'd1;
                        default:   tally_n_d = tally_n_q + 3'd1;
                    endcase
                    if (win_cnt_q == LAST_WIN) begin
                        state_d = ST_DECIDE;
                    end else begin
                        win_cnt_d = win_cnt_q + 3'd1;
                        tmr_load  = 1'b1;
                        tmr_value = TMR_W'(WINDOW_CYCLES - 1);
                    end
                end
            end
            ST_DECIDE: begin
                if (!start) begin
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end else if (win_found) begin
                    cmd_dir_d  = win_dir;
                    cmd_conf_d = win_tally;
                    state_d    = ST_ISSUE;
                end else begin
                    clear     = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(SETTLE_CYCLES - 1);
                    state_d   = ST_SETTLE;
                end
            end
            ST_ISSUE: begin
                // start is deliberately ignored until the command is taken.
                if (cmd_ready) begin
                    if (start) begin
                        tmr_load  = 1'b1;
                        tmr_value = TMR_W'(COOLDOWN_CYCLES - 1);
                        state_d   = ST_COOLDOWN;
                    end else begin
                        clear   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (!start) begin
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmr_done) begin
                    clear     = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(SETTLE_CYCLES - 1);
                    state_d   = ST_SETTLE;
                end
            end
            default: begin
                clear   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        if (clear) begin
            tally_l_d = '0;
            tally_r_d = '0;
            tally_a_d = '0;
            tally_n_d = '0;
            win_cnt_d = '0;
        end
    end

    // State, tallies, previous direction and latched command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tally_l_q  <= '0;
            tally_r_q  <= '0;
            tally_a_q  <= '0;
            tally_n_q  <= '0;
            win_cnt_q  <= '0;
            dir_prev_q <= DIR_NONE;
            cmd_dir_q  <= DIR_NONE;
            cmd_conf_q <= '0;
        end else begin
            state_q    <= state_d;
            tally_l_q  <= tally_l_d;
            tally_r_q  <= tally_r_d;
            tally_a_q  <= tally_a_d;
            tally_n_q  <= tally_n_d;
            win_cnt_q  <= win_cnt_d;
            dir_prev_q <= direction;
            cmd_dir_q  <= cmd_dir_d;
            cmd_conf_q <= cmd_conf_d;
        end
    end

    // Outputs decode straight from the state so reset clears them at once.
    always_comb begin
        find_enable = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) || (state_q == ST_DECIDE);
        cmd_valid   = (state_q == ST_ISSUE);
        busy        = (state_q != ST_IDLE);
    end

    assign cmd_dir        = cmd_dir_q;
    assign cmd_confidence = cmd_conf_q;

endmodule

// File: tb/tb_sound_seek_sequencer.sv
// Self-checking bench for sound_seek_sequencer with short cycle parameters.
module tb_sound_seek_sequencer;

    localparam int SETTLE   = 10;
    localparam int WINDOW   = 20;
    localparam int VOTES    = 5;
    localparam int COOLDOWN = 15;
    localparam int ROUND    = 1 + SETTLE + VOTES * WINDOW;
    localparam int MAXC     = 400;
    localparam int NR       = 3 * ROUND + 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       cmd_ready = 1'b0;
    logic [1:0] direction = 2'b00;
    logic       find_enable;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic [2:0] cmd_confidence;
    logic       busy;

    always #5 clk = ~clk;

    sound_seek_sequencer #(
        .SETTLE_CYCLES   (SETTLE),
        .WINDOW_CYCLES   (WINDOW),
        .VOTES           (VOTES),
        .COOLDOWN_CYCLES (COOLDOWN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .find_enable    (find_enable),
        .direction      (direction),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_dir        (cmd_dir),
        .cmd_confidence (cmd_confidence),
        .busy           (busy)
    );

    logic [1:0] dseq    [MAXC];
    logic       st_seq  [MAXC];
    logic       rdy_seq [MAXC];
    logic       fe_tr   [MAXC];
    logic       vl_tr   [MAXC];
    logic       by_tr   [MAXC];
    logic [1:0] dr_tr   [MAXC];
    logic [2:0] cf_tr   [MAXC];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [4:0][1:0] w;
        logic            has_cmd;
        logic [1:0]      dir;
        logic [2:0]      conf;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                                input logic [1:0] d, input logic [1:0] e,
                                input logic h, input logic [1:0] dr, input logic [2:0] cf);
        vec_t v;
        v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e;
        v.has_cmd = h; v.dir = dr; v.conf = cf;
        return v;
    endfunction

    task automatic fill(input logic [1:0] d, input logic s, input logic r);
        for (int c = 0; c < MAXC; c++) begin
            dseq[c] = d; st_seq[c] = s; rdy_seq[c] = r;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; cmd_ready = 1'b0; direction = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Cycle c: inputs driven just after the c-th edge, outputs sampled at the falling edge.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            start = st_seq[c]; direction = dseq[c]; cmd_ready = rdy_seq[c];
            @(negedge clk);
            fe_tr[c] = find_enable; vl_tr[c] = cmd_valid; by_tr[c] = busy;
            dr_tr[c] = cmd_dir; cf_tr[c] = cmd_confidence;
        end
    endtask

    function automatic int first_valid(input int n);
        for (int c = 0; c < n; c++) if (vl_tr[c] === 1'b1) return c;
        return -1;
    endfunction

    function automatic int count_fe(input int lo, input int hi, input logic val);
        int k;
        k = 0;
        for (int c = lo; c <= hi; c++) if (fe_tr[c] === val) k++;
        return k;
    endfunction

    // Reference: with start held high from cycle b0, round r begins at b0 + r*ROUND;
    // window k of a round is sampled at base+SETTLE+(k+1)*WINDOW and the
    // command appears one cycle after the decide cycle.
    function automatic void model(input int b0, input int n, output int vc,
                                  output logic [1:0] vd, output logic [2:0] vf);
        int base;
        int cnt [4];
        int s, c, best;
        logic strict;
        vc = -1; vd = 2'b00; vf = 3'd0;
        base = b0;
        while (base + ROUND + 1 < n) begin
            cnt = '{0, 0, 0, 0};
            for (int k = 0; k < VOTES; k++) begin
                c = base + SETTLE + (k + 1) * WINDOW;
                s = (dseq[c] == dseq[c-1]) ? int'(dseq[c]) : 0;
                cnt[s]++;
            end
            best = 0;
            for (int d = 1; d < 4; d++) begin
                strict = 1'b1;
                for (int e = 1; e < 4; e++) if (e != d && cnt[e] >= cnt[d]) strict = 1'b0;
                if (strict && cnt[d] > VOTES / 2) best = d;
            end
            if (best != 0) begin
                vc = base + ROUND + 1; vd = 2'(best); vf = 3'(cnt[best]);
                return;
            end
            base += ROUND;
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv, vc, hs, bad, k;
        logic [1:0] vd, d;
        logic [2:0] vf;

        vecs[0] = mk(2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 1'b1, 2'd1, 3'd5);
        vecs[1] = mk(2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0, 3'd0);
        vecs[2] = mk(2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 1'b1, 2'd1, 3'd3);
        vecs[3] = mk(2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 1'b0, 2'd0, 3'd0);
        vecs[4] = mk(2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 1'b1, 2'd2, 3'd4);
        vecs[5] = mk(2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 1'b1, 2'd3, 3'd3);
        vecs[6] = mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0);
        vecs[7] = mk(2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 1'b1, 2'd3, 3'd3);
        vecs[8] = mk(2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 1'b1, 2'd1, 3'd3);

        // Reset state
        do_reset();
        chk("rst_find_enable", find_enable, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_dir", cmd_dir, 0);
        chk("rst_conf", cmd_confidence, 0);

        // Constant LEFT, ready always high
        fill(2'd1, 1'b1, 1'b1);
        run(130);
        chk("t1_busy_c0", by_tr[0], 0);
        chk("t1_fe_c0", fe_tr[0], 0);
        chk("t1_busy_c1", by_tr[1], 1);
        chk("t1_fe_c1", fe_tr[1], 1);
        chk("t1_first_valid", first_valid(130), 112);
        chk("t1_fe_c111", fe_tr[111], 1);
        chk("t1_fe_c112", fe_tr[112], 0);
        chk("t1_dir", dr_tr[112], 1);
        chk("t1_conf", cf_tr[112], 5);
        chk("t1_valid_c113", vl_tr[113], 0);
        chk("t1_cooldown_fe_high", count_fe(113, 127, 1'b1), 0);
        chk("t1_fe_c128", fe_tr[128], 1);

        // Ready held low for 30 cycles
        do_reset();
        fill(2'd1, 1'b1, 1'b1);
        for (int c = 0; c < 142; c++) rdy_seq[c] = 1'b0;
        run(160);
        chk("t2_first_valid", first_valid(160), 112);
        for (int c = 112; c <= 142; c++) begin
            chk($sformatf("t2_valid_c%0d", c), vl_tr[c], 1);
            chk($sformatf("t2_dir_c%0d", c), dr_tr[c], 1);
            chk($sformatf("t2_conf_c%0d", c), cf_tr[c], 5);
        end
        chk("t2_valid_c143", vl_tr[143], 0);
        chk("t2_cooldown_fe_high", count_fe(143, 157, 1'b1), 0);
        chk("t2_fe_c158", fe_tr[158], 1);

        // Table of per-window vote patterns
        for (int i = 0; i < 9; i++) begin
            do_reset();
            fill(2'd0, 1'b1, 1'b1);
            for (int c = 0; c < MAXC; c++) begin
                k = (c < SETTLE + 1) ? 0 : (c - SETTLE - 1) / WINDOW;
                dseq[c] = (k < VOTES) ? vecs[i].w[k] : 2'd0;
            end
            run(150);
            if (vecs[i].has_cmd) begin
                chk($sformatf("vec%0d_first_valid", i), first_valid(150), 112);
                chk($sformatf("vec%0d_dir", i), dr_tr[112], vecs[i].dir);
                chk($sformatf("vec%0d_conf", i), cf_tr[112], vecs[i].conf);
            end else begin
                chk($sformatf("vec%0d_first_valid", i), first_valid(150), -1);
                chk($sformatf("vec%0d_fe_low_cycles", i), count_fe(1, 149, 1'b0), 0);
                chk($sformatf("vec%0d_busy_c112", i), by_tr[112], 1);
            end
        end

        // Direction changes exactly on every window's last cycle
        do_reset();
        fill(2'd1, 1'b1, 1'b1);
        for (int c = 0; c < MAXC; c++) begin
            k = c % ROUND;
            if (k >= SETTLE + WINDOW && ((k - SETTLE) % WINDOW) == 0) dseq[c] = 2'd2;
        end
        run(240);
        model(0, 240, vc, vd, vf);
        chk("t5_toggle_first_valid", first_valid(240), vc);
        chk("t5_toggle_fe_low_cycles", count_fe(1, 239, 1'b0), 0);

        // start dropped mid-MEASURE after two RIGHT votes, then re-armed with L,L,L,R,R
        do_reset();
        fill(2'd2, 1'b1, 1'b1);
        for (int c = 51; c < 60; c++) st_seq[c] = 1'b0;
        for (int c = 60; c < MAXC; c++) begin
            k = (c - 60 < SETTLE + 1) ? 0 : (c - 60 - SETTLE - 1) / WINDOW;
            dseq[c] = (k < 3) ? 2'd1 : 2'd2;
        end
        run(180);
        chk("t5_drop_fe_c51", fe_tr[51], 1);
        chk("t5_drop_fe_c52", fe_tr[52], 0);
        chk("t5_drop_busy_c52", by_tr[52], 0);
        chk("t5_rearm_first_valid", first_valid(180), 172);
        chk("t5_rearm_dir", dr_tr[172], 1);
        chk("t5_rearm_conf", cf_tr[172], 3);

        // Asynchronous reset while a command is pending
        do_reset();
        fill(2'd1, 1'b1, 1'b0);
        run(120);
        chk("t6_valid_before_reset", vl_tr[119], 1);
        #2;
        reset = 1'b1; start = 1'b0; cmd_ready = 1'b0;
        #1;
        chk("t6_valid_in_reset", cmd_valid, 0);
        chk("t6_fe_in_reset", find_enable, 0);
        chk("t6_busy_in_reset", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        fill(2'd1, 1'b1, 1'b1);
        run(115);
        chk("t6_first_valid", first_valid(115), 112);
        chk("t6_dir", dr_tr[112], 1);
        chk("t6_conf", cf_tr[112], 5);

        // Randomized direction streams and ready timing against the reference model
        for (int t = 0; t < 6; t++) begin
            do_reset();
            d = 2'($urandom_range(0, 3));
            for (int c = 0; c < MAXC; c++) begin
                dseq[c]    = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : d;
                st_seq[c]  = 1'b1;
                rdy_seq[c] = ($urandom_range(0, 2) != 0);
            end
            run(NR);
            model(0, NR, vc, vd, vf);
            fv = first_valid(NR);
            chk($sformatf("rnd%0d_first_valid", t), fv, vc);
            bad = 0;
            for (int c = 0; c < NR; c++) if (vl_tr[c] === 1'b1 && dr_tr[c] === 2'd0) bad++;
            chk($sformatf("rnd%0d_dir_none_while_valid", t), bad, 0);
            if (vc >= 0 && fv == vc) begin
                chk($sformatf("rnd%0d_dir", t), dr_tr[vc], vd);
                chk($sformatf("rnd%0d_conf", t), cf_tr[vc], vf);
                chk($sformatf("rnd%0d_fe_in_issue", t), fe_tr[vc], 0);
                hs = -1;
                for (int c = vc; c < NR; c++) if (hs < 0 && rdy_seq[c]) hs = c;
                if (hs >= 0 && hs + 1 < NR) begin
                    bad = 0;
                    for (int c = vc; c <= hs; c++)
                        if (vl_tr[c] !== 1'b1 || dr_tr[c] !== vd || cf_tr[c] !== vf) bad++;
                    chk($sformatf("rnd%0d_hold_until_ready", t), bad, 0);
                    chk($sformatf("rnd%0d_valid_after_hs", t), vl_tr[hs+1], 0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
